core_bus_arbiter: RTL and testbench

Two-requester Wishbone-classic arbiter that shares the single processor memory port between the core's instruction-fetch path and its data (load/store) path. It is used when the second memory bus is not exposed. It sits between the core wrapper and the Controller's core bus. It serialises transactions, latches the winning request, drives the shared bus until ack or timeout, and returns a one-cycle ack with registered read data to the winning requester.

---
 rtl/core_bus_arbiter_if.sv | 54 +++++
 rtl/core_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// Handshake and shared-bus signal bundle for core_bus_arbiter.
// master: arbiter view; slave: requesters and memory side.
interface core_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_ack_o;
  logic                  if_err_o;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [SW-1:0]         d_wstrb_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_ack_o;
  logic                  d_err_o;

  logic                  m_cyc_o;
  logic                  m_stb_o;
  logic                  m_we_o;
  logic [SW-1:0]         m_wstrb_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [DATA_WIDTH-1:0] m_data_i;
  logic                  m_ack_i;

  modport master (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o, if_err_o,
    input  d_req_i, d_we_i, d_wstrb_i,
    input  d_addr_i, d_wdata_i,
    output d_rdata_o, d_ack_o, d_err_o,
    output m_cyc_o, m_stb_o, m_we_o,
    output m_wstrb_o, m_addr_o, m_data_o,
    input  m_data_i, m_ack_i
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o, if_err_o,
    output d_req_i, d_we_i, d_wstrb_i,
    output d_addr_i, d_wdata_i,
    input  d_rdata_o, d_ack_o, d_err_o,
    input  m_cyc_o, m_stb_o, m_we_o,
    input  m_wstrb_o, m_addr_o, m_data_o,
    output m_data_i, m_ack_i
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Fetch/data arbiter onto one Wishbone-classic core bus port.
// Define ARB_ROUND_ROBIN_EN for alternating grant on contention.
module core_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  core_bus_arbiter_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, BUS, RESP
  } state_t;

  state_t r_state, w_state;
  logic   r_gnt_d, w_gnt_d;
  logic   r_cyc, w_cyc;
  logic   r_we, w_we;
  logic [SW-1:0]         r_wstrb, w_wstrb;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [15:0]           r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_if_rdata, w_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata;
  logic r_if_ack, w_if_ack;
  logic r_d_ack, w_d_ack;
  logic r_if_err, w_if_err;
  logic r_d_err, w_d_err;
  logic w_any_req;
  logic w_pick_d;

  assign w_any_req = bus.if_req_i | bus.d_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d, w_last_d;

  // On contention, grant whoever did not win last
  always_comb begin
    w_pick_d = bus.d_req_i;
    if (bus.d_req_i && bus.if_req_i)
      w_pick_d = ~r_last_d;
  end

  assign w_last_d =
    (r_state == IDLE && w_any_req) ? w_pick_d : r_last_d;

  // Last-grant memory, starts as "data"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_d <= 1'b1;
    else        r_last_d <= w_last_d;
  end
`else
  assign w_pick_d = bus.d_req_i;
`endif

  // Next-state and next-register values
  always_comb begin
    w_state    = r_state;
    w_gnt_d    = r_gnt_d;
    w_cyc      = r_cyc;
    w_we       = r_we;
    w_wstrb    = r_wstrb;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_cnt      = r_cnt;
    w_if_rdata = r_if_rdata;
    w_d_rdata  = r_d_rdata;
    w_if_err   = r_if_err;
    w_d_err    = r_d_err;
    w_if_ack   = 1'b0;
    w_d_ack    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state = BUS;
          w_cyc   = 1'b1;
          w_cnt   = '0;
          w_gnt_d = w_pick_d;
          if (w_pick_d) begin
            w_we    = bus.d_we_i;
            w_wstrb = bus.d_wstrb_i;
            w_addr  = bus.d_addr_i;
            w_wdata = bus.d_wdata_i;
          end else begin
            w_we    = 1'b0;
            w_wstrb = '1;
            w_addr  = bus.if_addr_i;
            w_wdata = '0;
          end
        end
      end
      BUS: begin
        if (bus.m_ack_i) begin
          w_state = RESP;
          w_cyc   = 1'b0;
          if (r_gnt_d) begin
            w_d_rdata = bus.m_data_i;
            w_d_err   = 1'b0;
            w_d_ack   = 1'b1;
          end else begin
            w_if_rdata = bus.m_data_i;
            w_if_err   = 1'b0;
            w_if_ack   = 1'b1;
          end
        end else if (r_cnt == TO_LAST) begin
          w_state = RESP;
          w_cyc   = 1'b0;
          if (r_gnt_d) begin
            w_d_rdata = '0;
            w_d_err   = 1'b1;
            w_d_ack   = 1'b1;
          end else begin
            w_if_rdata = '0;
            w_if_err   = 1'b1;
            w_if_ack   = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      RESP: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt_d    <= 1'b0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_wstrb    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_gnt_d    <= w_gnt_d;
      r_cyc      <= w_cyc;
      r_we       <= w_we;
      r_wstrb    <= w_wstrb;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_cnt      <= w_cnt;
      r_if_rdata <= w_if_rdata;
      r_d_rdata  <= w_d_rdata;
      r_if_ack   <= w_if_ack;
      r_d_ack    <= w_d_ack;
      r_if_err   <= w_if_err;
      r_d_err    <= w_d_err;
    end
  end

  assign bus.m_cyc_o    = r_cyc;
  assign bus.m_stb_o    = r_cyc;
  assign bus.m_we_o     = r_we;
  assign bus.m_wstrb_o  = r_wstrb;
  assign bus.m_addr_o   = r_addr;
  assign bus.m_data_o   = r_wdata;
  assign bus.if_rdata_o = r_if_rdata;
  assign bus.if_ack_o   = r_if_ack;
  assign bus.if_err_o   = r_if_err;
  assign bus.d_rdata_o  = r_d_rdata;
  assign bus.d_ack_o    = r_d_ack;
  assign bus.d_err_o    = r_d_err;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Testbench for core_bus_arbiter.
// Vector table plus reset and hold sequences.
module tb_core_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   last_d = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  core_bus_arbiter_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  core_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    string       name;
    bit          rq_if;
    bit          rq_d;
    logic [31:0] if_addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] d_addr;
    logic [31:0] wdata;
    int          lat0;
    logic [31:0] rd0;
    int          lat1;
    logic [31:0] rd1;
    bit          scramble;
  } vec_t;

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_bus;
    int          t_req;
    bit          scramble;
  } exp_t;

  exp_t q[$];
  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic bit pick_d(bit rq_if, bit rq_d);
`ifdef ARB_ROUND_ROBIN_EN
    if (rq_if && rq_d) return !last_d;
`endif
    return rq_d;
  endfunction

  function automatic exp_t mk(vec_t v, bit is_d,
                              int lat, logic [31:0] rd,
                              int t_req);
    exp_t e;
    bit   to;
    to = (lat == 0) || (lat > TO);
    e.name     = {v.name, is_d ? ".d" : ".if"};
    e.is_d     = is_d;
    e.we       = is_d ? v.we : 1'b0;
    e.wstrb    = is_d ? v.wstrb : 4'hF;
    e.addr     = is_d ? v.d_addr : v.if_addr;
    e.wdata    = v.wdata;
    e.lat      = lat;
    e.rd       = rd;
    e.exp_rd   = to ? 32'h0 : rd;
    e.exp_err  = to;
    e.exp_bus  = to ? TO : lat;
    e.t_req    = t_req;
    e.scramble = v.scramble;
    return e;
  endfunction

  task automatic engine(input int budget);
    int   bus_n = 0;
    exp_t e;
    while (q.size() > 0) begin
      if (budget == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: no ack within budget",
                 q[0].name);
        q.delete();
        break;
      end
      budget--;
      @(negedge clk);
      if (bus.if_ack_o || bus.d_ack_o) begin
        e = q.pop_front();
        chk({e.name, " ack port"},
            {30'd0, bus.d_ack_o, bus.if_ack_o},
            e.is_d ? 32'd2 : 32'd1);
        chk({e.name, " bus cycles"}, bus_n, e.exp_bus);
        chk({e.name, " rdata"},
            e.is_d ? bus.d_rdata_o : bus.if_rdata_o,
            e.exp_rd);
        chk({e.name, " err"},
            e.is_d ? bus.d_err_o : bus.if_err_o,
            {31'd0, e.exp_err});
        if (e.is_d) bus.d_req_i = 1'b0;
        else        bus.if_req_i = 1'b0;
      end
      if (bus.m_stb_o && q.size() > 0) begin
        e = q[0];
        if (bus_n == 0 && e.t_req >= 0)
          chk({e.name, " stb latency"}, cyc, e.t_req + 1);
        bus_n++;
        chk({e.name, " m_cyc"}, bus.m_cyc_o, 1);
        chk({e.name, " m_we"}, bus.m_we_o, {31'd0, e.we});
        chk({e.name, " m_wstrb"}, bus.m_wstrb_o, e.wstrb);
        chk({e.name, " m_addr"}, bus.m_addr_o, e.addr);
        if (e.is_d)
          chk({e.name, " m_data"}, bus.m_data_o, e.wdata);
        if (e.scramble) begin
          bus.d_addr_i  = $urandom;
          bus.d_wdata_i = $urandom;
          bus.d_we_i    = ~bus.d_we_i;
          bus.d_wstrb_i = ~bus.d_wstrb_i;
        end
        bus.m_ack_i  = (bus_n == e.lat);
        bus.m_data_i = bus.m_ack_i ? e.rd : 32'hA5A5_5A5A;
      end else if (bus.m_stb_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious stb: got 1 expected 0");
        bus.m_ack_i = 1'b0;
      end else begin
        bus_n = 0;
        bus.m_ack_i = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit w;
    @(negedge clk);
    chk({v.name, " idle no ack"},
        {30'd0, bus.d_ack_o, bus.if_ack_o}, 0);
    w = pick_d(v.rq_if, v.rq_d);
    q.push_back(mk(v, w, v.lat0, v.rd0, cyc));
    last_d = w;
    if (v.rq_if && v.rq_d) begin
      q.push_back(mk(v, !w, v.lat1, v.rd1, -1));
      last_d = !w;
    end
    bus.if_req_i  = v.rq_if;
    bus.if_addr_i = v.if_addr;
    bus.d_req_i   = v.rq_d;
    bus.d_we_i    = v.we;
    bus.d_wstrb_i = v.wstrb;
    bus.d_addr_i  = v.d_addr;
    bus.d_wdata_i = v.wdata;
    engine(200);
  endtask

  function automatic vec_t V(string n, bit ri, bit rd,
      logic [31:0] ia, bit we, logic [3:0] ws,
      logic [31:0] da, logic [31:0] wd,
      int l0, logic [31:0] r0,
      int l1, logic [31:0] r1, bit sc);
    vec_t v;
    v.name = n; v.rq_if = ri; v.rq_d = rd;
    v.if_addr = ia; v.we = we; v.wstrb = ws;
    v.d_addr = da; v.wdata = wd;
    v.lat0 = l0; v.rd0 = r0;
    v.lat1 = l1; v.rd1 = r1;
    v.scramble = sc;
    return v;
  endfunction

  initial begin
    vt.push_back(V("fetch", 1, 0, 32'h100, 0, 4'h0,
      0, 0, 2, 32'h13, 0, 0, 0));
    vt.push_back(V("dwrite", 0, 1, 0, 1, 4'h3,
      32'h2000, 32'hDEADBEEF, 3, 32'h0, 0, 0, 1));
    vt.push_back(V("cont1", 1, 1, 32'h104, 0, 4'hF,
      32'h3000, 32'h0, 1, 32'hAAAA0001,
      1, 32'hBBBB0002, 0));
    vt.push_back(V("cont2", 1, 1, 32'h108, 1, 4'hC,
      32'h3004, 32'h0BAD_F00D, 1, 32'hCCCC0003,
      2, 32'hDDDD0004, 0));
    vt.push_back(V("d_tmo", 0, 1, 0, 0, 4'hF,
      32'h4000, 0, 0, 32'h9999, 0, 0, 0));
    vt.push_back(V("d_after", 0, 1, 0, 0, 4'hF,
      32'h4004, 0, 3, 32'h12345678, 0, 0, 0));
    vt.push_back(V("coinc", 1, 0, 32'h200, 0, 4'h0,
      0, 0, TO, 32'h55, 0, 0, 0));
    vt.push_back(V("d_tmo2", 0, 1, 0, 1, 4'h1,
      32'h4008, 32'h1, TO + 1, 32'h66, 0, 0, 0));

    rst_n         = 1'b0;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_wstrb_i = '0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    bus.m_data_i  = '0;
    bus.m_ack_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset m_stb", bus.m_stb_o, 0);
    chk("reset m_addr", bus.m_addr_o, 0);
    chk("reset acks",
        {28'd0, bus.d_ack_o, bus.if_ack_o,
         bus.d_err_o, bus.if_err_o}, 0);
    chk("reset rdata", bus.if_rdata_o | bus.d_rdata_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      run_vec(vt[i]);

    // rdata holds across the other port; err holds
    @(negedge clk);
    chk("hold if_rdata", bus.if_rdata_o, 32'h55);
    chk("hold if_err", bus.if_err_o, 0);
    chk("hold d_err", bus.d_err_o, 1);
    chk("hold d_rdata", bus.d_rdata_o, 0);
    run_vec(V("f_only", 1, 0, 32'h300, 0, 4'h0,
      0, 0, 1, 32'h77, 0, 0, 0));
    chk("d_err after fetch", bus.d_err_o, 1);
    run_vec(V("d_clr", 0, 1, 0, 0, 4'hF,
      32'h4010, 0, 2, 32'h88, 0, 0, 0));

    // Reset while the bus cycle is open
    @(negedge clk);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_wstrb_i = 4'hF;
    bus.d_addr_i  = 32'h5000;
    bus.d_wdata_i = 32'h1234;
    repeat (2) @(negedge clk);
    chk("rst pre stb", bus.m_stb_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async stb",
        {30'd0, bus.m_cyc_o, bus.m_stb_o}, 0);
    chk("rst async m_*",
        bus.m_addr_o | bus.m_data_o |
        {27'd0, bus.m_wstrb_o, bus.m_we_o}, 0);
    chk("rst async rdata",
        bus.if_rdata_o | bus.d_rdata_o, 0);
    bus.d_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no ack",
          {28'd0, bus.d_ack_o, bus.if_ack_o,
           bus.d_err_o, bus.if_err_o}, 0);
    end
    rst_n  = 1'b1;
    last_d = 1'b1;
    run_vec(V("post_rst", 1, 0, 32'h400, 0, 4'h0,
      0, 0, 1, 32'hCAFE0001, 0, 0, 0));
    run_vec(V("post_cont", 1, 1, 32'h404, 0, 4'hF,
      32'h6000, 0, 1, 32'h1, 1, 32'h2, 0));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
